// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage for a simple in-order pipeline. Holds the program
// counter, reads a combinational instruction memory and presents one IF/ID
// bundle at a time to the decode stage using a valid/ready handshake.
//
// Parameters
//   RESET_PC     PC value loaded while reset is asserted
//   HALT_OPCODE  opcode (instr[31:26]) that stops further fetching
//
// Ports
//   clk          single clock, all state updates on the rising edge
//   rst_n        asynchronous, active-low reset
//   imem_addr    byte address to instruction memory (equals pc)
//   imem_instr   instruction word for imem_addr, same cycle
//   stall        freezes pc and suppresses new fetches
//   redirect     taken branch / jump, highest priority
//   redirect_pc  redirect target (low two bits ignored)
//   out_valid    IF/ID bundle valid
//   out_ready    decode stage accepts the bundle
//   out_instr    fetched instruction
//   out_pc       address of out_instr
//   halted       high while the fetch FSM sits in HALT
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = 6'd63
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic        load;
    logic        halt_hit;

    assign imem_addr = pc;

    // A fetch happens only when running, not frozen, not being redirected,
    // and the output slot is either empty or being drained this cycle.
    assign load     = (state == RUN) && !stall && !redirect && (!out_valid || out_ready);
    assign halt_hit = (imem_instr[31:26] == HALT_OPCODE);

    // State register; halted is registered alongside so it tracks the state
    // exactly without a combinational decode on the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= BOOT;
            halted <= 1'b0;
        end else begin
            state  <= state_next;
            halted <= (state_next == HALT);
        end
    end

    // Next-state logic. BOOT always leaves after one edge (a redirect seen
    // in BOOT only moves the pc). A redirect pulls RUN/HALT back to RUN.
    always_comb begin
        state_next = state;
        case (state)
            BOOT: state_next = RUN;
            RUN: begin
                if (redirect)
                    state_next = RUN;
                else if (load && halt_hit)
                    state_next = HALT;
            end
            HALT: begin
                if (redirect)
                    state_next = RUN;
            end
            default: state_next = BOOT;
        endcase
    end

    // PC and IF/ID bundle. Redirect flushes the bundle and wins over
    // everything; otherwise a load fills the bundle, otherwise a consumed
    // bundle is retired while its data is kept for visibility.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            out_instr <= 32'h0000_0000;
            out_pc    <= 32'h0000_0000;
        end else if (redirect) begin
            pc        <= {redirect_pc[31:2], 2'b00};
            out_valid <= 1'b0;
        end else if (load) begin
            out_instr <= imem_instr;
            out_pc    <= pc;
            out_valid <= 1'b1;
            pc        <= pc + 32'd4;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage: basic fetch, backpressure, stall versus
// redirect, halt and resume, address wrap, redirect in BOOT and asynchronous
// reset. A 16-word instruction memory model indexed by imem_addr[5:2]
// answers combinationally.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;

    logic [31:0] mem [16];

    int assertCount;
    int failCount;

    fetch_stage #(
        .RESET_PC    (32'h0000_0000),
        .HALT_OPCODE (6'd63)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_addr   (imem_addr),
        .imem_instr  (imem_instr),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .halted      (halted)
    );

    assign imem_instr = mem[imem_addr[5:2]];

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive the control inputs; they take effect at the next rising edge.
    task automatic applyStimulus(input logic stl, input logic rdr,
                                 input logic [31:0] rpc, input logic rdy);
        stall       = stl;
        redirect    = rdr;
        redirect_pc = rpc;
        out_ready   = rdy;
    endtask

    // Advance one edge and settle 1 time unit after it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        assert (actual === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, actual, expected);
        end
    endtask

    // Check the full bundle in one go.
    task automatic checkBundle(input string tag, input logic v,
                               input logic [31:0] pcv, input logic [31:0] ins,
                               input logic [31:0] addr);
        checkOutput({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        checkOutput({tag, ".pc"},    out_pc,    pcv);
        checkOutput({tag, ".instr"}, out_instr, ins);
        checkOutput({tag, ".addr"},  imem_addr, addr);
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        for (int i = 0; i < 16; i++)
            mem[i] = 32'h0100_0000 + i;
        mem[0] = 32'h1004_000A;

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        #2;
        checkBundle("reset", 1'b0, 32'h0, 32'h0, 32'h0);
        checkOutput("reset.halted", {31'd0, halted}, 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // ---------------- basic fetch ----------------
        step();
        checkOutput("boot.valid", {31'd0, out_valid}, 32'd0);
        step();
        checkBundle("fetch0", 1'b1, 32'h0, 32'h1004_000A, 32'h4);
        step();
        checkBundle("fetch4", 1'b1, 32'h4, 32'h0100_0001, 32'h8);
        step();
        checkBundle("fetch8", 1'b1, 32'h8, 32'h0100_0002, 32'hC);
        step();
        checkBundle("fetch12", 1'b1, 32'hC, 32'h0100_0003, 32'h10);

        // ---------------- backpressure ----------------
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
        checkBundle("bp.first", 1'b1, 32'h0, 32'h1004_000A, 32'h4);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkBundle("bp.hold", 1'b1, 32'h0, 32'h1004_000A, 32'h4);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        step();
        checkBundle("bp.next", 1'b1, 32'h4, 32'h0100_0001, 32'h8);

        // ---------------- stall versus redirect ----------------
        applyStimulus(1'b1, 1'b1, 32'h0000_0043, 1'b1);
        step();
        checkOutput("sr.valid", {31'd0, out_valid}, 32'd0);
        checkOutput("sr.addr", imem_addr, 32'h0000_0040);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        step();
        checkOutput("sr.stallvalid", {31'd0, out_valid}, 32'd0);
        checkOutput("sr.stalladdr", imem_addr, 32'h0000_0040);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        step();
        checkBundle("sr.resume", 1'b1, 32'h40, 32'h1004_000A, 32'h44);

        // Stall keeps an unconsumed bundle, then lets it drain via out_ready.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        step();
        checkBundle("stall.hold", 1'b1, 32'h40, 32'h1004_000A, 32'h44);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        step();
        checkOutput("stall.drain", {31'd0, out_valid}, 32'd0);
        checkOutput("stall.addr", imem_addr, 32'h44);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        step();
        checkBundle("stall.after", 1'b1, 32'h44, 32'h0100_0001, 32'h48);

        // ---------------- halt and resume ----------------
        mem[2] = 32'hFC00_0000;
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b1);
        step();
        checkOutput("halt.flush", {31'd0, out_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        step();
        step();
        checkBundle("halt.pc4", 1'b1, 32'h4, 32'h0100_0001, 32'h8);
        checkOutput("halt.notyet", {31'd0, halted}, 32'd0);
        step();
        checkBundle("halt.bundle", 1'b1, 32'h8, 32'hFC00_0000, 32'hC);
        checkOutput("halt.halted", {31'd0, halted}, 32'd1);
        step();
        checkOutput("halt.consumed", {31'd0, out_valid}, 32'd0);
        checkOutput("halt.addr", imem_addr, 32'hC);
        step();
        checkOutput("halt.stay", {31'd0, halted}, 32'd1);
        checkOutput("halt.noload", {31'd0, out_valid}, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b1);
        step();
        checkOutput("halt.release", {31'd0, halted}, 32'd0);
        checkOutput("halt.raddr", imem_addr, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        step();
        checkBundle("halt.resume", 1'b1, 32'h0, 32'h1004_000A, 32'h4);
        mem[2] = 32'h0100_0002;

        // ---------------- address wrap ----------------
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        step();
        checkOutput("wrap.addr", imem_addr, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        step();
        checkBundle("wrap.top", 1'b1, 32'hFFFF_FFFC, 32'h0100_000F, 32'h0);
        step();
        checkBundle("wrap.zero", 1'b1, 32'h0, 32'h1004_000A, 32'h4);

        // ---------------- asynchronous reset ----------------
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("areset.valid", {31'd0, out_valid}, 32'd0);
        checkOutput("areset.addr", imem_addr, 32'h0);
        checkOutput("areset.pc", out_pc, 32'h0);
        checkOutput("areset.instr", out_instr, 32'h0);
        // Redirect and stall are ignored while reset is held.
        applyStimulus(1'b1, 1'b1, 32'h0000_0080, 1'b1);
        step();
        checkOutput("areset.ignore", imem_addr, 32'h0);
        checkOutput("areset.halted", {31'd0, halted}, 32'd0);

        // Redirect in BOOT moves the pc and still enters RUN.
        applyStimulus(1'b0, 1'b1, 32'h0000_0020, 1'b1);
        rst_n = 1'b1;
        step();
        checkOutput("bootr.valid", {31'd0, out_valid}, 32'd0);
        checkOutput("bootr.addr", imem_addr, 32'h20);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        step();
        checkBundle("bootr.fetch", 1'b1, 32'h20, 32'h0100_0008, 32'h24);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
